// File: rtl/mp64_clk_pkg.sv
// Shared clock/reset definitions: reset-sequencer state codes and status widths.
// Also used by the CSR status decoder.
package mp64_clk_pkg;

    localparam int STATE_W = 3;
    localparam int LLC_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        RST_S_RESET  = 3'd0,
        RST_S_WAIT   = 3'd1,
        RST_S_STABLE = 3'd2,
        RST_S_RUN    = 3'd3,
        RST_S_FAIL   = 3'd4
    } rst_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mp64_sync2.sv
// Generic two-flop synchronizer for asynchronous status inputs; resets to 0.
module mp64_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mp64_pll_ctl.sv
// PLL lock supervisor: pulses PLL reset, waits for and qualifies lock, then
// releases system reset; any lock loss in RUN re-cycles the PLL.
module mp64_pll_ctl
    import mp64_clk_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [LLC_W-1:0]   lock_loss_cnt
);

    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_LIMIT   = RET_W'(MAX_RETRIES);

    logic             locked_s;
    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retry_q, retry_d, retry_inc;
    logic [LLC_W-1:0] llc_q;
    logic             llc_inc;
    logic             pll_rst_q, sys_rst_n_q, fail_q;

    mp64_sync2 #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_S_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            llc_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == RST_S_RESET) || (state_d == RST_S_FAIL);
            sys_rst_n_q <= (state_d == RST_S_RUN);
            fail_q      <= (state_d == RST_S_FAIL);
            if (llc_inc && (llc_q != {LLC_W{1'b1}})) begin
                llc_q <= llc_q + LLC_W'(1);
            end
        end
    end

    // restart overrides everything, including a coincident RUN lock loss
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        llc_inc   = 1'b0;
        retry_inc = retry_q + RET_W'(1);
        if (restart) begin
            state_d = RST_S_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = RST_S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RST_S_WAIT: begin
                    if (locked_s) begin
                        state_d = RST_S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RET_LIMIT) ? RST_S_FAIL : RST_S_RESET;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RST_S_STABLE: begin
                    if (!locked_s) begin
                        state_d = RST_S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RST_S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RST_S_RUN: begin
                    if (!locked_s) begin
                        state_d = RST_S_RESET;
                        cnt_d   = '0;
                        llc_inc = 1'b1;
                    end
                end
                RST_S_FAIL: begin
                    state_d = RST_S_FAIL;
                end
                default: begin
                    state_d = RST_S_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst_n     = sys_rst_n_q;
    assign fail          = fail_q;
    assign state         = state_q;
    assign lock_loss_cnt = llc_q;

endmodule
